e_mdu: RTL

- Multi-cycle multiply/divide unit for the execute stage, companion to the single-cycle execute ALU; owns the HI/LO architectural registers.
- Operand width, multiply latency and divide latency are parameters.
- Start/busy handshake lets hazard logic stall the MFHI/MFLO/MTHI/MTLO and multiply/divide instructions that follow.
- A cancel input discards an in-flight operation when the execute stage is flushed by an exception.

---
 rtl/e_mdu_pkg.sv | 32 +++
 rtl/e_mdu_if.sv | 19 +
 rtl/e_mdu_core.sv | 57 +++++
 rtl/e_mdu.sv | 101 ++++++++++
 4 files changed

// File: rtl/e_mdu_pkg.sv
// Shared constants for the execute-stage multiply/divide unit.
// Op encodings sit alongside the ALU control constants used by the decoder.
// Also holds FSM state codes and a small op-classification helper.
package e_mdu_pkg;

   typedef logic [2:0] mdu_op_t;

   // Operation encodings driven by the decoder; 7 is reserved and acts as NONE
   localparam mdu_op_t mdu_NONE  = 3'd0;
   localparam mdu_op_t mdu_MULT  = 3'd1;
   localparam mdu_op_t mdu_MULTU = 3'd2;
   localparam mdu_op_t mdu_DIV   = 3'd3;
   localparam mdu_op_t mdu_DIVU  = 3'd4;
   localparam mdu_op_t mdu_MTHI  = 3'd5;
   localparam mdu_op_t mdu_MTLO  = 3'd6;

   // FSM state codes
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // True for the multi-cycle operations that enter RUN
   function automatic logic is_muldiv(input mdu_op_t op);
      return (op == mdu_MULT) || (op == mdu_MULTU) ||
             (op == mdu_DIV)  || (op == mdu_DIVU);
   endfunction

   // True for the multiply pair (selects MUL_LAT rather than DIV_LAT)
   function automatic logic is_mul(input mdu_op_t op);
      return (op == mdu_MULT) || (op == mdu_MULTU);
   endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
// The execute stage is the master; the MDU is the slave.
// busy is the only backpressure: hazard logic stalls dependent instructions on it.
interface e_mdu_if #(parameter int WIDTH = 32);
   import e_mdu_pkg::*;

   logic             start;
   mdu_op_t          op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             cancel;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, A, B, cancel, input busy, hi, lo);
   modport slave  (input start, op, A, B, cancel, output busy, hi, lo);

endinterface

// File: rtl/e_mdu_core.sv
// Combinational HI/LO result generator for the latched op and operands.
// Latency: none (pure logic); the top-level counter models the multi-cycle timing.
// Backpressure: not applicable; result is sampled only on the completion edge.
module e_mdu_core
   import e_mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  mdu_op_t          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi_nxt,
   output logic [WIDTH-1:0] lo_nxt
);

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic signed [2*WIDTH-1:0] prod_s;
   logic        [2*WIDTH-1:0] prod_u;

   // Full-width products; signed operands are sign-extended by the 2*WIDTH context
   assign prod_s = $signed(a) * $signed(b);
   assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

   // Select the result; divide-by-zero and most-negative/-1 get fixed answers
   always_comb begin
      hi_nxt = '0;
      lo_nxt = '0;
      if (op == mdu_MULT) begin
         {hi_nxt, lo_nxt} = prod_s;
      end else if (op == mdu_MULTU) begin
         {hi_nxt, lo_nxt} = prod_u;
      end else if (op == mdu_DIV) begin
         if (b == '0) begin
            lo_nxt = ALL_ONES;
            hi_nxt = a;
         end else if ((a == MOST_NEG) && (b == ALL_ONES)) begin
            lo_nxt = MOST_NEG;
            hi_nxt = '0;
         end else begin
            // SV signed / and % truncate toward zero, remainder follows dividend
            lo_nxt = $signed(a) / $signed(b);
            hi_nxt = $signed(a) % $signed(b);
         end
      end else if (op == mdu_DIVU) begin
         if (b == '0) begin
            lo_nxt = ALL_ONES;
            hi_nxt = a;
         end else begin
            lo_nxt = a / b;
            hi_nxt = a % b;
         end
      end
   end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit owning the HI/LO registers.
// Latency: MUL_LAT cycles busy for MULT/MULTU, DIV_LAT for DIV/DIVU; MTHI/MTLO single edge.
// Backpressure: busy is registered; start while busy is ignored, cancel aborts without touching HI/LO.
module e_mdu
   import e_mdu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input logic    clk,
   input logic    reset,
   e_mdu_if.slave bus
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   mdu_op_t          op_q,    op_d;
   logic [WIDTH-1:0] a_q,     a_d;
   logic [WIDTH-1:0] b_q,     b_d;
   logic [WIDTH-1:0] hi_q,    hi_d;
   logic [WIDTH-1:0] lo_q,    lo_d;

   logic [WIDTH-1:0] core_hi;
   logic [WIDTH-1:0] core_lo;

   e_mdu_core #(.WIDTH(WIDTH)) u_core (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .hi_nxt (core_hi),
      .lo_nxt (core_lo)
   );

   // Next-state: issue from IDLE, count down in RUN, cancel wins over completion
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      if (state_q == ST_IDLE) begin
         if (bus.start && !bus.cancel) begin
            if (is_muldiv(bus.op)) begin
               state_d = ST_RUN;
               op_d    = bus.op;
               a_d     = bus.A;
               b_d     = bus.B;
               cnt_d   = is_mul(bus.op) ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
            end else if (bus.op == mdu_MTHI) begin
               hi_d = bus.A;
            end else if (bus.op == mdu_MTLO) begin
               lo_d = bus.A;
            end
         end
      end else begin
         if (bus.cancel) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               hi_d    = core_hi;
               lo_d    = core_lo;
            end
         end
      end
   end

   // State and architectural registers; reset aborts any operation at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= mdu_NONE;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign bus.busy = (state_q == ST_RUN);
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule
